axi_r_buffer: RTL and testbench
===============================

Name: axi_r_buffer

Overview:
- Parametrised AXI read-data (R channel) buffer between a slave-side R port and a master-side R port in the crossbar return path.
- Next-generation R FIFO:
  - uses all DEPTH entries;
  - valid/ready handshakes on both sides;
  - exposes occupancy level and almost-full;
  - optional packet mode releases data only once a complete burst (RLAST) is stored.

Parameters:
- ID_WIDTH, 4, RID width.
- DATA_WIDTH, 32, RDATA width.
- DEPTH, 4, number of entries; power of two, >= 2.
- AF_THRESH, DEPTH-1, almost_full asserts when level >= AF_THRESH; range 1..DEPTH.
- PACKET_MODE, 0, 0 = cut-through; 1 = store-and-forward per burst.

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESETn  in  1  synchronous active-low reset
- s_RID  in  ID_WIDTH  incoming RID
- s_RDATA  in  DATA_WIDTH  incoming RDATA
- s_RRESP  in  2  incoming RRESP
- s_RLAST  in  1  incoming RLAST
- s_RVALID  in  1  incoming beat valid
- s_RREADY  out  1  buffer can accept a beat
- m_RID  out  ID_WIDTH  head RID
- m_RDATA  out  DATA_WIDTH  head RDATA
- m_RRESP  out  2  head RRESP
- m_RLAST  out  1  head RLAST
- m_RVALID  out  1  head beat valid
- m_RREADY  in  1  downstream accepts head beat
- level  out  $clog2(DEPTH)+1  entries stored, 0..DEPTH
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level >= AF_THRESH

Behaviour:
- Reset (ARESETn low at a rising edge) clears the following; storage contents are not reset:
  - wr_ptr, rd_ptr, level, burst_cnt and flush all go to 0.
  - After reset: level=0, empty=1, full=0, almost_full=0 (AF_THRESH >= 1), m_RVALID=0, s_RREADY=1.
- Reset asserted mid-operation discards all stored beats; no push or pop happens in a cycle where ARESETn is low.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. level is a separate counter and distinguishes full from empty.
- push = s_RVALID & s_RREADY, where s_RREADY = ~full. s_RREADY has no combinational path from m_RREADY; no push while full, even if a pop occurs that cycle.
- Push writes {s_RID, s_RDATA, s_RRESP, s_RLAST} to entry wr_ptr; wr_ptr increments.
- pop = m_RVALID & m_RREADY; rd_ptr increments.
- m_* payload is a combinational read of entry rd_ptr. It is stable while m_RVALID=1 and m_RREADY=0.
- Latency: a beat pushed in cycle N is visible on m_* with m_RVALID=1 in cycle N+1 at the earliest. There is no same-cycle pass-through.
- level update:
  - push & pop: unchanged.
  - push only: +1.
  - pop only: -1.
- full, empty and almost_full are decoded from the registered level.
- PACKET_MODE=0: m_RVALID = ~empty.
- PACKET_MODE=1, burst_cnt:
  - burst_cnt, width $clog2(DEPTH)+1, counts stored beats with RLAST=1.
  - Incremented on a push with s_RLAST=1; decremented on a pop with m_RLAST=1; unchanged when both occur.
  - m_RVALID = ~empty & ((burst_cnt != 0) | flush).
- PACKET_MODE=1, flush (deadlock escape for bursts longer than DEPTH):
  - Set when full & (burst_cnt == 0).
  - Cleared on a pop with m_RLAST=1; clear has priority over set in the same cycle.
  - While flush=1, beats drain cut-through until the partial burst's RLAST leaves.
- In PACKET_MODE=0, burst_cnt and flush are still maintained but do not affect any output.
- Out-of-range operation is impossible by construction:
  - push is blocked when full;
  - pop requires m_RVALID, which implies ~empty.

Test Plan:
- Reset, then push 4 beats back-to-back (DEPTH=4, RDATA=0x11..0x44), m_RREADY=0 -> level 1,2,3,4; full=1 and s_RREADY=0 after the 4th; almost_full=1 from level 3; 5th beat stalls; RDATA unchanged at head=0x11.
- Full buffer, drain with m_RREADY=1 -> order 0x11,0x22,0x33,0x44, one per cycle; empty=1 after the last; write 8 more beats -> pointer wrap, order preserved.
- Half full (level=2), s_RVALID=1 and m_RREADY=1 for 10 cycles -> level stays 2; output sequence equals input sequence delayed by 2 beats.
- PACKET_MODE=1, push a 3-beat burst one beat per cycle -> m_RVALID=0 until the cycle after RLAST is pushed, then 3 beats drain with m_RLAST on the 3rd; burst_cnt returns to 0.
- PACKET_MODE=1, DEPTH=4, push an 8-beat burst -> at level=4 with burst_cnt=0, flush=1; m_RVALID=1; all 8 beats delivered in order; flush=0 after the RLAST pop.
- Assert ARESETn=0 for 1 cycle while level=3 and m_RVALID=1 -> next cycle level=0, empty=1, m_RVALID=0, s_RREADY=1; the next pushed beat is the first delivered.

Source files
------------

// File: rtl/axi_r_buffer.sv
// AXI R-channel return buffer: DEPTH-entry FIFO with occupancy flags and an
// optional store-and-forward mode that holds data until a whole burst is stored.
module axi_r_buffer #(
    parameter int ID_WIDTH    = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int AF_THRESH   = DEPTH - 1,
    parameter int PACKET_MODE = 0
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic [ID_WIDTH-1:0]         s_RID,
    input  logic [DATA_WIDTH-1:0]       s_RDATA,
    input  logic [1:0]                  s_RRESP,
    input  logic                        s_RLAST,
    input  logic                        s_RVALID,
    output logic                        s_RREADY,
    output logic [ID_WIDTH-1:0]         m_RID,
    output logic [DATA_WIDTH-1:0]       m_RDATA,
    output logic [1:0]                  m_RRESP,
    output logic                        m_RLAST,
    output logic                        m_RVALID,
    input  logic                        m_RREADY,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = ID_WIDTH + DATA_WIDTH + 3;

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             flush_q, flush_d;

    logic push;
    logic pop;
    logic last_in;
    logic last_out;

    assign full        = (level_q == LVL_W'(DEPTH));
    assign empty       = (level_q == '0);
    assign almost_full = (level_q >= LVL_W'(AF_THRESH));
    assign level       = level_q;

    // Ready depends only on registered state, never on m_RREADY.
    assign s_RREADY = ~full;
    assign m_RVALID = ~empty & ((PACKET_MODE == 0) | (burst_cnt_q != '0) | flush_q);

    assign {m_RID, m_RDATA, m_RRESP, m_RLAST} = mem_q[rd_ptr_q];

    assign push     = s_RVALID & s_RREADY;
    assign pop      = m_RVALID & m_RREADY;
    assign last_in  = push & s_RLAST;
    assign last_out = pop & m_RLAST;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        burst_cnt_d = burst_cnt_q;
        flush_d     = flush_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        case ({last_in, last_out})
            2'b10:   burst_cnt_d = burst_cnt_q + LVL_W'(1);
            2'b01:   burst_cnt_d = burst_cnt_q - LVL_W'(1);
            default: burst_cnt_d = burst_cnt_q;
        endcase

        // A full buffer with no complete burst can never release data on its
        // own, so drain cut-through until the partial burst's last beat leaves.
        if (last_out)
            flush_d = 1'b0;
        else if (full && (burst_cnt_q == '0))
            flush_d = 1'b1;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            burst_cnt_q <= '0;
            flush_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            burst_cnt_q <= burst_cnt_d;
            flush_q     <= flush_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESETn && push)
            mem_q[wr_ptr_q] <= {s_RID, s_RDATA, s_RRESP, s_RLAST};
    end

endmodule

// File: tb/tb_axi_r_buffer.sv
// Bench for axi_r_buffer: a cut-through and a packet-mode instance share one
// stimulus stream and are each checked every cycle against a queue model.
module tb_axi_r_buffer;

    localparam int DEPTH = 4;
    localparam int AFT   = 3;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [3:0]  s_RID;
    logic [31:0] s_RDATA;
    logic [1:0]  s_RRESP;
    logic        s_RLAST;
    logic        s_RVALID;
    logic        m_RREADY;

    logic [3:0]  o_rid    [2];
    logic [31:0] o_rdata  [2];
    logic [1:0]  o_rresp  [2];
    logic        o_rlast  [2];
    logic        o_rvalid [2];
    logic        o_srdy   [2];
    logic [2:0]  o_lvl    [2];
    logic        o_full   [2];
    logic        o_empty  [2];
    logic        o_af     [2];

    int n_tests = 0;
    int n_fail  = 0;

    beat_t mq [2][$];
    logic  mflush [2];

    always #5 ACLK = ~ACLK;

    axi_r_buffer #(.ID_WIDTH(4), .DATA_WIDTH(32), .DEPTH(DEPTH), .AF_THRESH(AFT), .PACKET_MODE(0)) u_ct (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s_RID(s_RID), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP), .s_RLAST(s_RLAST),
        .s_RVALID(s_RVALID), .s_RREADY(o_srdy[0]),
        .m_RID(o_rid[0]), .m_RDATA(o_rdata[0]), .m_RRESP(o_rresp[0]), .m_RLAST(o_rlast[0]),
        .m_RVALID(o_rvalid[0]), .m_RREADY(m_RREADY),
        .level(o_lvl[0]), .full(o_full[0]), .empty(o_empty[0]), .almost_full(o_af[0])
    );

    axi_r_buffer #(.ID_WIDTH(4), .DATA_WIDTH(32), .DEPTH(DEPTH), .AF_THRESH(AFT), .PACKET_MODE(1)) u_pk (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s_RID(s_RID), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP), .s_RLAST(s_RLAST),
        .s_RVALID(s_RVALID), .s_RREADY(o_srdy[1]),
        .m_RID(o_rid[1]), .m_RDATA(o_rdata[1]), .m_RRESP(o_rresp[1]), .m_RLAST(o_rlast[1]),
        .m_RVALID(o_rvalid[1]), .m_RREADY(m_RREADY),
        .level(o_lvl[1]), .full(o_full[1]), .empty(o_empty[1]), .almost_full(o_af[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nlast(int k);
        int n = 0;
        for (int i = 0; i < mq[k].size(); i++)
            if (mq[k][i].last) n++;
        return n;
    endfunction

    // Instance 0 is cut-through; instance 1 releases only complete bursts or while flushing.
    function automatic bit mvalid(int k);
        if (mq[k].size() == 0) return 1'b0;
        if (k == 0) return 1'b1;
        return (nlast(k) != 0) || mflush[k];
    endfunction

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            int sz = mq[k].size();
            chk($sformatf("level%0d", k), o_lvl[k], sz);
            chk($sformatf("full%0d", k), o_full[k], sz == DEPTH);
            chk($sformatf("empty%0d", k), o_empty[k], sz == 0);
            chk($sformatf("afull%0d", k), o_af[k], sz >= AFT);
            chk($sformatf("s_rready%0d", k), o_srdy[k], sz < DEPTH);
            chk($sformatf("m_rvalid%0d", k), o_rvalid[k], mvalid(k));
            if (mvalid(k))
                chk($sformatf("payload%0d", k), {o_rid[k], o_rdata[k], o_rresp[k], o_rlast[k]}, mq[k][0]);
        end
    endtask

    task automatic model_step();
        if (!ARESETn) begin
            for (int k = 0; k < 2; k++) begin
                mq[k].delete();
                mflush[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit do_pop  = mvalid(k) && m_RREADY;
                bit do_push = s_RVALID && (mq[k].size() < DEPTH);
                bit is_full = (mq[k].size() == DEPTH);
                int nl      = nlast(k);
                if (do_pop && mq[k][0].last)
                    mflush[k] = 1'b0;
                else if (is_full && nl == 0)
                    mflush[k] = 1'b1;
                if (do_pop) void'(mq[k].pop_front());
                if (do_push) mq[k].push_back({s_RID, s_RDATA, s_RRESP, s_RLAST});
            end
        end
    endtask

    bit chk_en = 1'b0;

    task automatic tick();
        @(negedge ACLK);
        if (chk_en) compare_all();
        @(posedge ACLK);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        ARESETn  = 1'b0;
        s_RVALID = 1'b0;
        s_RLAST  = 1'b0;
        m_RREADY = 1'b0;
        tick();
        tick();
        ARESETn = 1'b1;
        chk_en  = 1'b1;
    endtask

    task automatic put(input logic [31:0] d, input logic l);
        s_RVALID = 1'b1;
        s_RDATA  = d;
        s_RLAST  = l;
        s_RID    = d[3:0];
        s_RRESP  = d[5:4];
    endtask

    // Push n beats from base upward on instance k while collecting its pops.
    task automatic stream(input int k, input int start, input int n, input logic [31:0] base, input int last_idx);
        int npush = start;
        int npop  = 0;
        for (int c = 0; c < 200 && npop < n; c++) begin
            bit acc;
            if (npush < n) put(base + npush, npush == last_idx);
            else s_RVALID = 1'b0;
            acc = s_RVALID && o_srdy[k];
            if (o_rvalid[k] && m_RREADY) begin
                chk($sformatf("stream%0d_data", k), o_rdata[k], base + npop);
                npop++;
            end
            tick();
            if (acc) npush++;
        end
        s_RVALID = 1'b0;
        chk($sformatf("stream%0d_count", k), npop, n);
    endtask

    initial begin
        s_RID = 4'h0; s_RDATA = '0; s_RRESP = 2'b00;
        do_reset();

        for (int k = 0; k < 2; k++) begin
            chk("rst_level", o_lvl[k], 0);
            chk("rst_empty", o_empty[k], 1);
            chk("rst_full", o_full[k], 0);
            chk("rst_afull", o_af[k], 0);
            chk("rst_mvalid", o_rvalid[k], 0);
            chk("rst_srready", o_srdy[k], 1);
        end

        // Fill with downstream stalled.
        for (int i = 0; i < 4; i++) begin
            put(32'h11 * (i + 1), 1'b0);
            tick();
            chk("fill_level", o_lvl[0], i + 1);
            chk("fill_afull", o_af[0], (i + 1) >= 3);
        end
        chk("fill_full", o_full[0], 1);
        chk("fill_srready", o_srdy[0], 0);
        put(32'h55, 1'b0);
        tick();
        tick();
        chk("stall_level", o_lvl[0], 4);
        chk("stall_head", o_rdata[0], 32'h11);

        // Drain in order, one per cycle.
        s_RVALID = 1'b0;
        m_RREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", o_rvalid[0], 1);
            chk("drain_data", o_rdata[0], 32'h11 * (i + 1));
            tick();
        end
        chk("drain_empty", o_empty[0], 1);

        // Eight more beats wrap the pointers.
        stream(0, 0, 8, 32'hA0, 99);

        // Steady state at level 2: output equals input delayed by two beats.
        do_reset();
        put(32'h200, 1'b0); tick();
        put(32'h201, 1'b0); tick();
        m_RREADY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            put(32'h100 + i, 1'b0);
            chk("half_level", o_lvl[0], 2);
            chk("half_data", o_rdata[0], (i < 2) ? (32'h200 + i) : (32'h100 + i - 2));
            tick();
        end
        s_RVALID = 1'b0;

        // Packet mode: a 3-beat burst is held until its last beat is stored.
        do_reset();
        m_RREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            put(32'h300 + i, i == 2);
            tick();
            if (i < 2) chk("pkt_hold", o_rvalid[1], 0);
        end
        s_RVALID = 1'b0;
        chk("pkt_release", o_rvalid[1], 1);
        for (int j = 0; j < 3; j++) begin
            chk("pkt_valid", o_rvalid[1], 1);
            chk("pkt_data", o_rdata[1], 32'h300 + j);
            chk("pkt_last", o_rlast[1], j == 2);
            tick();
        end
        chk("pkt_empty", o_empty[1], 1);
        chk("pkt_idle", o_rvalid[1], 0);

        // Packet mode: a burst longer than the buffer forces a flush.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            put(32'h400 + i, 1'b0);
            tick();
        end
        s_RVALID = 1'b0;
        chk("flush_level", o_lvl[1], 4);
        chk("flush_pre", o_rvalid[1], 0);
        tick();
        chk("flush_on", o_rvalid[1], 1);
        m_RREADY = 1'b1;
        stream(1, 4, 8, 32'h400, 7);
        m_RREADY = 1'b0;
        put(32'h4FF, 1'b0);
        tick();
        s_RVALID = 1'b0;
        tick();
        chk("flush_off_level", o_lvl[1], 1);
        chk("flush_off", o_rvalid[1], 0);

        // Reset in the middle of traffic discards contents.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            put(32'h500 + i, 1'b0);
            tick();
        end
        chk("mid_level", o_lvl[0], 3);
        chk("mid_valid", o_rvalid[0], 1);
        ARESETn = 1'b0;
        put(32'h5EE, 1'b0);
        tick();
        ARESETn  = 1'b1;
        s_RVALID = 1'b0;
        chk("mid_rst_level", o_lvl[0], 0);
        chk("mid_rst_empty", o_empty[0], 1);
        chk("mid_rst_valid", o_rvalid[0], 0);
        chk("mid_rst_ready", o_srdy[0], 1);
        put(32'h577, 1'b0);
        tick();
        s_RVALID = 1'b0;
        chk("mid_first_valid", o_rvalid[0], 1);
        chk("mid_first_data", o_rdata[0], 32'h577);

        // Random traffic with varying downstream pressure and rare resets.
        for (int c = 0; c < 4000; c++) begin
            int rp = (c / 500) % 4;
            ARESETn  = ($urandom_range(0, 249) != 0);
            s_RVALID = ($urandom_range(0, 9) < 7);
            s_RLAST  = ($urandom_range(0, 3) == 0);
            s_RDATA  = $urandom;
            s_RID    = 4'($urandom);
            s_RRESP  = 2'($urandom);
            m_RREADY = ($urandom_range(0, 3) < rp + 1);
            tick();
        end
        ARESETn  = 1'b1;
        s_RVALID = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
